axi_burst_mem_slave: RTL
========================

AXI_BURST_MEM_SLAVE -- requirements
Module: axi_burst_mem_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of awaddr/araddr; word address, one increment per DATA_WIDTH word.
REQ-002 Parameter DATA_WIDTH, default 32, data word width; multiple of 8.
REQ-003 Parameter MEM_DEPTH, default 1024, words of storage; power of two, at least 2.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 awaddr  in  ADDR_WIDTH  write burst start word address; awlen  in  8  beats minus 1; awvalid  in  1; awready  out  1.
REQ-007 wdata  in  DATA_WIDTH; wstrb  in  DATA_WIDTH/8  byte enables; wvalid  in  1; wlast  in  1; wready  out  1.
REQ-008 bresp  out  2  00 OKAY, 10 SLVERR; bvalid  out  1; bready  in  1.
REQ-009 araddr  in  ADDR_WIDTH; arlen  in  8; arvalid  in  1; arready  out  1.
REQ-010 rdata  out  DATA_WIDTH; rresp  out  2; rvalid  out  1; rlast  out  1; rready  in  1.

Function
REQ-011 Write FSM states W_IDLE, W_DATA, W_RESP; read FSM states R_IDLE, R_DATA; the two run independently and concurrently.
REQ-012 awready is 1 exactly in W_IDLE; on awvalid&&awready, latch awaddr and awlen, clear beat counter and error flag, go to W_DATA.
REQ-013 wready is 1 exactly in W_DATA; each wvalid&&wready beat writes the bytes of wdata enabled by wstrb to the current address, then increments the address by 1.
REQ-014 A beat whose address is >= MEM_DEPTH is not written and sets the sticky error flag.
REQ-015 The burst ends on the beat with count == latched awlen; wlast on any other beat, or absent on the final beat, sets the error flag; then go to W_RESP.
REQ-016 W_RESP: bvalid=1, bresp = SLVERR if the error flag is set, else OKAY; on bready, go to W_IDLE with bvalid=0; bvalid and bresp stay stable while bready=0.
REQ-017 arready is 1 exactly in R_IDLE; on handshake, latch araddr and arlen and go to R_DATA; the first rvalid is asserted the next cycle (one-cycle latency).
REQ-018 In R_DATA: rdata = mem[addr] and rresp = OKAY if addr < MEM_DEPTH, else rdata=0 and rresp=SLVERR; rlast=1 when beat count == arlen.
REQ-019 rdata, rresp, rlast and rvalid hold stable while rvalid&&!rready; on each handshake, advance the address and count and present the next beat in the following cycle.
REQ-020 After the rlast handshake, clear rvalid and rlast and return to R_IDLE; a new AR is accepted no earlier than the cycle after.
REQ-021 awlen=0 or arlen=0 is a single-beat burst; the address counter is ADDR_WIDTH bits and wraps to 0 past all-ones.
REQ-022 A read beat and a write beat to the same address in the same cycle return the old (pre-write) data.
REQ-023 Address counters carry no further state between bursts.

Reset
REQ-024 While rst_n=0: both FSMs idle; awready, wready, bvalid, arready, rvalid and rlast driven 0; bresp, rresp and rdata driven 0; in-flight bursts are discarded with no response.
REQ-025 Handshake-ready outputs rise the first cycle after rst_n returns to 1.

Configuration
REQ-026 Macro AXI_MEM_INIT_EN defined: reset loads mem[i]=i+1 for every i; undefined: reset leaves memory contents unchanged and memory has no reset logic.

Verification
REQ-027 With AXI_MEM_INIT_EN: reset, read araddr=5, arlen=3, rready=1 -> rdata 6,7,8,9 on consecutive cycles, rlast on 9, rresp=OKAY.
REQ-028 Write awaddr=16, awlen=1, wdata A5A5A5A5 then 12345678, wstrb=F, wlast on beat 2 -> bresp=OKAY; readback of 16..17 returns the same data.
REQ-029 Write wstrb=0011, wdata=FFFFFFFF to a word holding 11223344 -> readback 1122FFFF.
REQ-030 Read araddr=MEM_DEPTH-1, arlen=1 -> beat 1 OKAY with stored data, beat 2 rdata=0 with rresp=SLVERR; write of the same range -> bresp=SLVERR, in-range word written.
REQ-031 rready toggled 1,0,0,1 during a 4-beat read -> rdata held stable during stalls, no beat lost or repeated; wlast asserted on beat 2 of a 4-beat write -> bresp=SLVERR after beat 4.
REQ-032 rst_n pulled low mid-burst in both directions -> all valid and ready outputs 0 the next cycle; after release, a fresh burst completes normally.

Source files
------------

// File: rtl/axi_burst_mem_slave.sv
// axi_burst_mem_slave
//   Word-addressed AXI-style burst memory slave. Independent write (AW/W/B)
//   and read (AR/R) engines share one MEM_DEPTH x DATA_WIDTH array.
//
//   Ports
//     clk, rst_n                       clock, synchronous active-low reset
//     awaddr/awlen/awvalid/awready     write burst request (awlen = beats-1)
//     wdata/wstrb/wvalid/wlast/wready  write data beats, byte enables
//     bresp/bvalid/bready              write response (00 OKAY, 10 SLVERR)
//     araddr/arlen/arvalid/arready     read burst request (arlen = beats-1)
//     rdata/rresp/rvalid/rlast/rready  read data beats
//
//   Macro AXI_MEM_INIT_EN: when defined, reset loads mem[i] = i+1; when
//   undefined the memory array has no reset at all.
module axi_burst_mem_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    input  logic                    wlast,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    output logic                    rlast,
    input  logic                    rready
);
    localparam int         IDX_W       = $clog2(MEM_DEPTH);
    localparam int         STRB_W      = DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    w_state_t              w_state, w_next;
    r_state_t              r_state, r_next;
    logic                  ready_en;
    logic [ADDR_WIDTH-1:0] w_addr, r_addr, rd_addr;
    logic [7:0]            w_len, w_cnt, r_len, r_cnt;
    logic                  w_err;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic                  rlast_q, rd_last;
    logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs, mem_we;

    // An address is backed by storage only if no bit at or above IDX_W is set.
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >> IDX_W) == '0;
    endfunction

    // Readies stay low through reset and come up the cycle after release.
    always_ff @(posedge clk) ready_en <= rst_n;

    assign awready = ready_en && rst_n && (w_state == W_IDLE);
    assign wready  = rst_n && (w_state == W_DATA);
    assign bvalid  = rst_n && (w_state == W_RESP);
    assign bresp   = (bvalid && w_err) ? RESP_SLVERR : RESP_OKAY;
    assign arready = ready_en && rst_n && (r_state == R_IDLE);
    assign rvalid  = rst_n && (r_state == R_DATA);
    assign rdata   = rst_n ? rdata_q : '0;
    assign rresp   = rst_n ? rresp_q : RESP_OKAY;
    assign rlast   = rst_n && rlast_q;

    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid && wready;
    assign b_hs   = bvalid && bready;
    assign ar_hs  = arvalid && arready;
    assign r_hs   = rvalid && rready;
    assign mem_we = w_hs && in_range(w_addr);

    // ---------------- write engine ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) w_state <= W_IDLE;
        else        w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        unique case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && (w_cnt == w_len)) w_next = W_RESP;
            W_RESP:  if (b_hs) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_addr <= '0;
            w_len  <= '0;
            w_cnt  <= '0;
            w_err  <= 1'b0;
        end else if (aw_hs) begin
            w_addr <= awaddr;
            w_len  <= awlen;
            w_cnt  <= '0;
            w_err  <= 1'b0;
        end else if (w_hs) begin
            w_addr <= w_addr + ADDR_WIDTH'(1);
            w_cnt  <= w_cnt + 8'd1;
            // Sticky: out-of-range beat, or wlast not exactly on the final beat.
            if (!in_range(w_addr) || (wlast != (w_cnt == w_len)))
                w_err <= 1'b1;
        end
    end

`ifdef AXI_MEM_INIT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_DEPTH; i++)
                mem[i] <= DATA_WIDTH'(i + 1);
        end else if (mem_we) begin
            for (int b = 0; b < STRB_W; b++)
                if (wstrb[b]) mem[w_addr[IDX_W-1:0]][b*8 +: 8] <= wdata[b*8 +: 8];
        end
    end
`else
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++)
                if (wstrb[b]) mem[w_addr[IDX_W-1:0]][b*8 +: 8] <= wdata[b*8 +: 8];
        end
    end
`endif

    // ---------------- read engine ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (r_hs && rlast_q) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Address of the beat being loaded into the output register: the burst
    // start on AR, else the next word. Loading at the clock edge means a write
    // landing on the same edge is not yet visible, so reads see old data.
    assign rd_addr = ar_hs ? araddr : r_addr + ADDR_WIDTH'(1);
    assign rd_last = ar_hs ? (arlen == 8'd0) : ((r_cnt + 8'd1) == r_len);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
            rlast_q <= 1'b0;
        end else if (ar_hs || (r_hs && !rlast_q)) begin
            r_addr  <= rd_addr;
            r_len   <= ar_hs ? arlen : r_len;
            r_cnt   <= ar_hs ? 8'd0 : r_cnt + 8'd1;
            rdata_q <= in_range(rd_addr) ? mem[rd_addr[IDX_W-1:0]] : '0;
            rresp_q <= in_range(rd_addr) ? RESP_OKAY : RESP_SLVERR;
            rlast_q <= rd_last;
        end else if (r_hs) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
            rlast_q <= 1'b0;
        end
    end

endmodule
